// File: rtl/cu_pkg.sv
// Shared unit codes, enable bit positions and pipeline stage records for the compute-unit issue controller.
package cu_pkg;

   localparam int CU_ADDR_W = 4;

   localparam logic [1:0] CU_UNIT_ALU = 2'd0;
   localparam logic [1:0] CU_UNIT_MUL = 2'd1;
   localparam logic [1:0] CU_UNIT_SHF = 2'd2;
   localparam logic [1:0] CU_UNIT_NOP = 2'd3;

   localparam int CU_EN_ALU = 0;
   localparam int CU_EN_MUL = 1;
   localparam int CU_EN_SHF = 2;

   typedef struct packed {
      logic                 valid;
      logic [1:0]           unit;
      logic [CU_ADDR_W-1:0] rx;
      logic [CU_ADDR_W-1:0] ry;
      logic [CU_ADDR_W-1:0] rn;
      logic                 wb;
   } cu_stage_t;

   // Writeback only needs the destination; sources are dropped after issue.
   typedef struct packed {
      logic                 valid;
      logic [1:0]           unit;
      logic [CU_ADDR_W-1:0] rn;
      logic                 wb;
   } cu_wb_stage_t;

   function automatic logic [2:0] cu_unit_onehot(input logic [1:0] unit);
      logic [2:0] oh;
      oh = 3'b000;
      case (unit)
         CU_UNIT_ALU: oh[CU_EN_ALU] = 1'b1;
         CU_UNIT_MUL: oh[CU_EN_MUL] = 1'b1;
         CU_UNIT_SHF: oh[CU_EN_SHF] = 1'b1;
         default:     oh = 3'b000;
      endcase
      return oh;
   endfunction

endpackage

// File: rtl/cu_wport_arb.sv
// Combinational register-file write-port arbiter; compute writeback always wins over bus-connect.
// A pending bus-connect request is acknowledged in the same cycle the port is free, otherwise it waits.
module cu_wport_arb
   import cu_pkg::*;
#(
   parameter int ADDRESS_WIDTH = CU_ADDR_W,
   parameter int SIGNAL_WIDTH  = 3
) (
   input  logic                     rst_i,
   input  cu_wb_stage_t             wb_stage_i,
   input  logic                     bc_req_i,
   input  logic [ADDRESS_WIDTH-1:0] bc_add_i,
   output logic [ADDRESS_WIDTH-1:0] wadd_o,
   output logic [SIGNAL_WIDTH-1:0]  cu_en_o,
   output logic                     bc_en_o,
   output logic                     bc_ack_o
);

   logic cu_wr;

   assign cu_wr = wb_stage_i.valid && wb_stage_i.wb && (wb_stage_i.unit != CU_UNIT_NOP);

   always_comb begin
      wadd_o   = '0;
      cu_en_o  = '0;
      bc_en_o  = 1'b0;
      bc_ack_o = 1'b0;
      if (cu_wr) begin
         wadd_o = wb_stage_i.rn;
         case (wb_stage_i.unit)
            CU_UNIT_ALU: cu_en_o[CU_EN_ALU] = 1'b1;
            CU_UNIT_MUL: cu_en_o[CU_EN_MUL] = 1'b1;
            CU_UNIT_SHF: cu_en_o[CU_EN_SHF] = 1'b1;
            default:     cu_en_o = '0;
         endcase
      end else if (bc_req_i && !rst_i) begin
         // Request is level-held by the bus-connect, so reset must mask it explicitly.
         wadd_o   = bc_add_i;
         bc_en_o  = 1'b1;
         bc_ack_o = 1'b1;
      end
   end

endmodule

// File: rtl/cu_issue_ctrl.sv
// Two-stage compute issue controller: reads/enables one cycle after accept, write select one cycle later.
// Never stalled downstream; with CU_HAZARD_STALL_EN defined, op_ready drops one cycle on a RAW hit against ISS.
module cu_issue_ctrl
   import cu_pkg::*;
#(
   parameter int ADDRESS_WIDTH = CU_ADDR_W,
   parameter int SIGNAL_WIDTH  = 3
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     op_valid,
   output logic                     op_ready,
   input  logic [1:0]               op_unit,
   input  logic [ADDRESS_WIDTH-1:0] op_rx,
   input  logic [ADDRESS_WIDTH-1:0] op_ry,
   input  logic [ADDRESS_WIDTH-1:0] op_rn,
   input  logic                     op_wb,
   input  logic                     bc_wr_req,
   input  logic [ADDRESS_WIDTH-1:0] bc_wr_add,
   output logic                     bc_wr_ack,
   output logic                     cu_alu_en,
   output logic                     cu_mul_en,
   output logic                     cu_shf_en,
   output logic [ADDRESS_WIDTH-1:0] cu_raddx,
   output logic [ADDRESS_WIDTH-1:0] cu_raddy,
   output logic [ADDRESS_WIDTH-1:0] cu_wadd,
   output logic [SIGNAL_WIDTH-1:0]  cu_w_cuEn,
   output logic                     cu_w_bcEn,
   output logic                     busy
);

   cu_stage_t    iss_q, iss_d;
   cu_wb_stage_t wb_q,  wb_d;
   logic         accept;
   logic [2:0]   unit_en;

`ifdef CU_HAZARD_STALL_EN
   logic hazard;

   // Only the ISS occupant can still be in flight when a consumer would read; WB commits this cycle.
   always_comb begin
      hazard = 1'b0;
      if (op_valid && (op_unit != CU_UNIT_NOP) && iss_q.valid && iss_q.wb) begin
         hazard = (op_rx == iss_q.rn) || (op_ry == iss_q.rn);
      end
   end

   assign op_ready = ~reset & ~hazard;
`else
   assign op_ready = ~reset;
`endif

   assign accept = op_valid & op_ready;

   always_comb begin
      iss_d = '0;
      if (accept) begin
         iss_d.valid = 1'b1;
         iss_d.unit  = op_unit;
         iss_d.rx    = op_rx;
         iss_d.ry    = op_ry;
         iss_d.rn    = op_rn;
         iss_d.wb    = op_wb;
      end
      wb_d = '0;
      if (iss_q.valid) begin
         wb_d.valid = 1'b1;
         wb_d.unit  = iss_q.unit;
         wb_d.rn    = iss_q.rn;
         wb_d.wb    = iss_q.wb;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         iss_q <= '0;
         wb_q  <= '0;
      end else begin
         iss_q <= iss_d;
         wb_q  <= wb_d;
      end
   end

   always_comb begin
      unit_en  = 3'b000;
      cu_raddx = '0;
      cu_raddy = '0;
      if (iss_q.valid) begin
         unit_en  = cu_unit_onehot(iss_q.unit);
         cu_raddx = iss_q.rx;
         cu_raddy = iss_q.ry;
      end
   end

   assign cu_alu_en = unit_en[CU_EN_ALU];
   assign cu_mul_en = unit_en[CU_EN_MUL];
   assign cu_shf_en = unit_en[CU_EN_SHF];
   assign busy      = iss_q.valid | wb_q.valid;

   cu_wport_arb #(
      .ADDRESS_WIDTH (ADDRESS_WIDTH),
      .SIGNAL_WIDTH  (SIGNAL_WIDTH)
   ) u_wport_arb (
      .rst_i      (reset),
      .wb_stage_i (wb_q),
      .bc_req_i   (bc_wr_req),
      .bc_add_i   (bc_wr_add),
      .wadd_o     (cu_wadd),
      .cu_en_o    (cu_w_cuEn),
      .bc_en_o    (cu_w_bcEn),
      .bc_ack_o   (bc_wr_ack)
   );

   a_unit_en_onehot : assert property (@(posedge clk) disable iff (reset)
      $onehot0({cu_shf_en, cu_mul_en, cu_alu_en}));

   a_wport_exclusive : assert property (@(posedge clk) disable iff (reset)
      !((|cu_w_cuEn) && cu_w_bcEn));

endmodule

// File: tb/tb_cu_issue_ctrl.sv
// Bench for cu_issue_ctrl: directed literal cases plus randomized traffic against a cycle-timeline model.
module tb_cu_issue_ctrl;

   localparam int AW = 4;
   localparam int SW = 3;
   localparam int NC = 8192;
`ifdef CU_HAZARD_STALL_EN
   localparam int STALL = 1;
`else
   localparam int STALL = 0;
`endif

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          op_valid = 1'b0;
   logic          op_ready;
   logic [1:0]    op_unit = 2'd0;
   logic [AW-1:0] op_rx = '0, op_ry = '0, op_rn = '0;
   logic          op_wb = 1'b0;
   logic          bc_wr_req = 1'b0;
   logic [AW-1:0] bc_wr_add = '0;
   logic          bc_wr_ack;
   logic          cu_alu_en, cu_mul_en, cu_shf_en;
   logic [AW-1:0] cu_raddx, cu_raddy, cu_wadd;
   logic [SW-1:0] cu_w_cuEn;
   logic          cu_w_bcEn;
   logic          busy;
   logic [2:0]    en_vec;

   int total = 0;
   int bad   = 0;

   assign en_vec = {cu_shf_en, cu_mul_en, cu_alu_en};

   cu_issue_ctrl #(.ADDRESS_WIDTH(AW), .SIGNAL_WIDTH(SW)) dut (
      .clk       (clk),
      .reset     (reset),
      .op_valid  (op_valid),
      .op_ready  (op_ready),
      .op_unit   (op_unit),
      .op_rx     (op_rx),
      .op_ry     (op_ry),
      .op_rn     (op_rn),
      .op_wb     (op_wb),
      .bc_wr_req (bc_wr_req),
      .bc_wr_add (bc_wr_add),
      .bc_wr_ack (bc_wr_ack),
      .cu_alu_en (cu_alu_en),
      .cu_mul_en (cu_mul_en),
      .cu_shf_en (cu_shf_en),
      .cu_raddx  (cu_raddx),
      .cu_raddy  (cu_raddy),
      .cu_wadd   (cu_wadd),
      .cu_w_cuEn (cu_w_cuEn),
      .cu_w_bcEn (cu_w_bcEn),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Timeline model: h_*[c] is the operation accepted at the edge closing cycle c.
   // In cycle n the issue slot holds h[n-1] and the writeback slot holds h[n-2].
   logic          h_vld [NC];
   logic [1:0]    h_unit[NC];
   logic [AW-1:0] h_rx[NC], h_ry[NC], h_rn[NC];
   logic          h_wb[NC];
   int            n = 2;
   logic          m_iv, m_wv, m_wr, m_bc, m_haz, m_rdy;
   logic [2:0]    m_en, m_cuen;
   logic [AW-1:0] m_wadd;

   initial begin
      for (int i = 0; i < NC; i++) h_vld[i] = 1'b0;
   end

   always @(negedge clk) begin
      m_iv = !reset && h_vld[n-1];
      m_wv = !reset && h_vld[n-2];
      m_en = (m_iv && h_unit[n-1] != 2'd3) ? 3'(1 << h_unit[n-1]) : 3'b000;
      m_wr = m_wv && h_wb[n-2] && (h_unit[n-2] != 2'd3);
      m_bc = !reset && !m_wr && bc_wr_req;
      m_cuen = m_wr ? 3'(1 << h_unit[n-2]) : 3'b000;
      m_wadd = m_wr ? h_rn[n-2] : (m_bc ? bc_wr_add : '0);
      m_haz = (STALL != 0) && op_valid && (op_unit != 2'd3) && m_iv && h_wb[n-1] &&
              ((op_rx == h_rn[n-1]) || (op_ry == h_rn[n-1]));
      m_rdy = !reset && !m_haz;

      check("m_op_ready", {31'b0, op_ready}, {31'b0, m_rdy});
      check("m_unit_en", {29'b0, en_vec}, {29'b0, m_en});
      check("m_raddx", {28'b0, cu_raddx}, m_iv ? {28'b0, h_rx[n-1]} : 32'd0);
      check("m_raddy", {28'b0, cu_raddy}, m_iv ? {28'b0, h_ry[n-1]} : 32'd0);
      check("m_cuEn", {29'b0, cu_w_cuEn}, {29'b0, m_cuen});
      check("m_bcEn", {31'b0, cu_w_bcEn}, {31'b0, m_bc});
      check("m_bc_ack", {31'b0, bc_wr_ack}, {31'b0, m_bc});
      check("m_wadd", {28'b0, cu_wadd}, {28'b0, m_wadd});
      check("m_busy", {31'b0, busy}, {31'b0, (m_iv | m_wv)});

      h_vld[n]  = op_valid && m_rdy;
      h_unit[n] = op_unit;
      h_rx[n]   = op_rx;
      h_ry[n]   = op_ry;
      h_rn[n]   = op_rn;
      h_wb[n]   = op_wb;
      if (reset) begin
         h_vld[n]   = 1'b0;
         h_vld[n-1] = 1'b0;
      end
      if (n < NC - 1) n++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic offer(input logic v, input logic [1:0] u, input logic [AW-1:0] x, input logic [AW-1:0] y,
                        input logic [AW-1:0] d, input logic w);
      op_valid = v; op_unit = u; op_rx = x; op_ry = y; op_rn = d; op_wb = w;
   endtask

   task automatic tick_idle();
      tick();
      offer(1'b0, 2'd0, '0, '0, '0, 1'b0);
   endtask

   // Offers an op in the next cycle and returns in its accept cycle with it still offered.
   task automatic send(input logic [1:0] u, input logic [AW-1:0] x, input logic [AW-1:0] y,
                       input logic [AW-1:0] d, input logic w, output int waits);
      tick();
      offer(1'b1, u, x, y, d, w);
      #2;
      waits = 0;
      while (!op_ready && waits < 8) begin
         tick();
         #2;
         waits++;
      end
      check("send_accept", {31'b0, op_ready}, 32'd1);
   endtask

   int  w0, w1;
   logic acc_prev, ack_prev;

   initial begin
      bc_wr_req = 1'b1;
      bc_wr_add = 4'd7;
      repeat (2) @(posedge clk);
      #3;
      check("rst_ready", {31'b0, op_ready}, 32'd0);
      check("rst_ack", {31'b0, bc_wr_ack}, 32'd0);
      check("rst_busy", {31'b0, busy}, 32'd0);
      check("rst_wadd", {28'b0, cu_wadd}, 32'd0);
      check("rst_bcEn", {31'b0, cu_w_bcEn}, 32'd0);
      tick();
      reset = 1'b0; bc_wr_req = 1'b0; bc_wr_add = '0;
      #2;
      check("rel_ready", {31'b0, op_ready}, 32'd1);
      check("idle_raddx", {28'b0, cu_raddx}, 32'd0);

      send(2'd0, 4'd1, 4'd2, 4'd3, 1'b1, w0);
      tick_idle(); #2;
      check("alu_en", {29'b0, en_vec}, 32'b001);
      check("alu_raddx", {28'b0, cu_raddx}, 32'd1);
      check("alu_raddy", {28'b0, cu_raddy}, 32'd2);
      tick(); #2;
      check("alu_cuEn", {29'b0, cu_w_cuEn}, 32'b001);
      check("alu_wadd", {28'b0, cu_wadd}, 32'd3);

      send(2'd1, 4'd4, 4'd5, 4'd6, 1'b1, w0);
      tick();
      offer(1'b1, 2'd2, 4'd7, 4'd8, 4'd9, 1'b1);
      #2;
      check("str_ready", {31'b0, op_ready}, 32'd1);
      check("str_mul_en", {29'b0, en_vec}, 32'b010);
      check("str_busy0", {31'b0, busy}, 32'd1);
      tick_idle(); #2;
      check("str_shf_en", {29'b0, en_vec}, 32'b100);
      check("str_mul_wr", {29'b0, cu_w_cuEn}, 32'b010);
      check("str_mul_wadd", {28'b0, cu_wadd}, 32'd6);
      tick(); #2;
      check("str_shf_wr", {29'b0, cu_w_cuEn}, 32'b100);
      check("str_shf_wadd", {28'b0, cu_wadd}, 32'd9);
      check("str_busy1", {31'b0, busy}, 32'd1);

      send(2'd0, 4'd1, 4'd2, 4'd5, 1'b1, w0);
      send(2'd1, 4'd5, 4'd0, 4'd6, 1'b1, w1);
      check("haz_prod_wait", w0, 32'd0);
      check("haz_cons_wait", w1, STALL);
      tick_idle(); #2;
      check("haz_mul_en", {29'b0, en_vec}, 32'b010);
      check("haz_mul_raddx", {28'b0, cu_raddx}, 32'd5);

      repeat (3) tick();
      send(2'd0, 4'd0, 4'd0, 4'd3, 1'b1, w0);
      tick_idle();
      tick();
      bc_wr_req = 1'b1; bc_wr_add = 4'd7;
      #2;
      check("bc_hold_ack", {31'b0, bc_wr_ack}, 32'd0);
      check("bc_hold_cuEn", {29'b0, cu_w_cuEn}, 32'b001);
      check("bc_hold_bcEn", {31'b0, cu_w_bcEn}, 32'd0);
      tick(); #2;
      check("bc_ack", {31'b0, bc_wr_ack}, 32'd1);
      check("bc_bcEn", {31'b0, cu_w_bcEn}, 32'd1);
      check("bc_wadd", {28'b0, cu_wadd}, 32'd7);
      tick();
      bc_wr_req = 1'b0; bc_wr_add = '0;

      send(2'd3, 4'd1, 4'd2, 4'd3, 1'b1, w0);
      tick_idle(); #2;
      check("nop_en", {29'b0, en_vec}, 32'b000);
      check("nop_busy", {31'b0, busy}, 32'd1);
      tick(); #2;
      check("nop_cuEn", {29'b0, cu_w_cuEn}, 32'b000);
      send(2'd0, 4'd9, 4'd10, 4'd4, 1'b0, w0);
      tick_idle(); #2;
      check("nowb_en", {29'b0, en_vec}, 32'b001);
      tick(); #2;
      check("nowb_cuEn", {29'b0, cu_w_cuEn}, 32'b000);
      check("nowb_wadd", {28'b0, cu_wadd}, 32'd0);

      repeat (2) tick();
      send(2'd0, 4'd1, 4'd2, 4'd8, 1'b1, w0);
      tick_idle(); #2;
      reset = 1'b1;
      #1;
      check("rmid_en", {29'b0, en_vec}, 32'b000);
      check("rmid_raddx", {28'b0, cu_raddx}, 32'd0);
      check("rmid_busy", {31'b0, busy}, 32'd0);
      check("rmid_ready", {31'b0, op_ready}, 32'd0);
      tick();
      reset = 1'b0;
      #2;
      check("rrel_ready", {31'b0, op_ready}, 32'd1);
      check("rrel_cuEn", {29'b0, cu_w_cuEn}, 32'b000);
      tick(); #2;
      check("rrel2_cuEn", {29'b0, cu_w_cuEn}, 32'b000);
      check("rrel2_busy", {31'b0, busy}, 32'd0);

      acc_prev = 1'b1;
      ack_prev = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         tick();
         reset = ($urandom_range(0, 99) == 0);
         if (!op_valid || acc_prev) begin
            offer($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), AW'($urandom_range(0, 3)),
                  AW'($urandom_range(0, 3)), AW'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
         end
         if (!bc_wr_req || ack_prev) begin
            bc_wr_req = ($urandom_range(0, 2) == 0);
            bc_wr_add = AW'($urandom_range(0, 15));
         end
         #2;
         acc_prev = op_valid && op_ready;
         ack_prev = bc_wr_ack;
      end
      tick();
      reset = 1'b0;
      offer(1'b0, 2'd0, '0, '0, '0, 1'b0);
      bc_wr_req = 1'b0;
      repeat (3) tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/cu_issue_ctrl.md
# cu_issue_ctrl

Compute-unit issue controller between the program sequencer and the compute-unit top (register file, crossbar, ALU, multiplier, shifter). It accepts decoded compute operations over a valid/ready handshake, drives register-file read addresses and unit enables in an issue stage, and drives the crossbar write enables and write address one cycle later. It also arbitrates the single register-file write port between compute results and bus-connect writes, and interlocks read-after-write hazards.

## Interface
- ADDRESS_WIDTH, 4: register-file address width.
- SIGNAL_WIDTH, 3: width of the compute write-enable vector; bit 0 ALU, bit 1 multiplier, bit 2 shifter.
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high.
- op_valid  in  1  operation offered.
- op_ready  out  1  operation accepted on the same edge as op_valid.
- op_unit  in  2  0 ALU, 1 multiplier, 2 shifter, 3 NOP (consumes a slot, no enable, no write).
- op_rx, op_ry, op_rn  in  ADDRESS_WIDTH each  source X, source Y, destination.
- op_wb  in  1  result is written to op_rn.
- bc_wr_req  in  1  bus-connect register write request; held until acknowledged.
- bc_wr_add  in  ADDRESS_WIDTH  bus-connect destination.
- bc_wr_ack  out  1  bus-connect write performed this cycle.
- cu_alu_en, cu_mul_en, cu_shf_en  out  1 each  unit enables, at most one high.
- cu_raddx, cu_raddy  out  ADDRESS_WIDTH  register-file read addresses.
- cu_wadd  out  ADDRESS_WIDTH  register-file write address.
- cu_w_cuEn  out  SIGNAL_WIDTH  one-hot compute write select.
- cu_w_bcEn  out  1  bus-connect write select.
- busy  out  1  issue or writeback stage valid.

## Operation
- Two registered stages: ISS (valid, unit, rx, ry, rn, wb) and WB (valid, unit, rn, wb).
- Accept edge: the ISS register loads the operation. ISS drives cu_raddx/cu_raddy and the one-hot unit enable.
- The next edge moves ISS into WB. WB with wb=1 drives cu_wadd=rn and cu_w_cuEn bit [unit]. A NOP or wb=0 drives no write.
- op_ready is high when the interlock is inactive and reset is low. The pipeline never stalls downstream, so ISS always advances.
- Interlock: when ISS is valid with wb=1 and the offered op_rx or op_ry equals ISS.rn, op_ready=0 for one cycle (a bubble enters ISS). A NOP offer is never interlocked.
- Write-port arbitration:
  - Compute writeback has priority.
  - When WB is not writing and bc_wr_req=1: cu_w_bcEn=1, cu_wadd=bc_wr_add, bc_wr_ack=1, all combinational in that cycle.
- When idle, all outputs are 0, including the addresses.

## Timing
- Reset values: every output is 0, except op_ready, which is 0 during reset and 1 in the first cycle after release. All stage valids are cleared.
- Reset mid-operation: the in-flight ISS and WB operations are discarded and no write is issued.
- Latency: the accept edge is E0, read and unit enable are in cycle C1, the write enable is in C2, and the register-file commit is at the end of C2.
- Back-to-back independent operations sustain one per cycle.
- Dependent operation immediately following its producer: the consumer is accepted one cycle late and reads in the producer's C2+1.
- bc_wr_req during continuous writebacks waits indefinitely (no fairness guarantee). It is acknowledged in the first cycle without a compute write.
- A simultaneous bc write and compute write never occurs. cu_w_cuEn and cu_w_bcEn are mutually exclusive.

## Configuration
- CU_HAZARD_STALL_EN defined: the interlock operates as above.
- CU_HAZARD_STALL_EN undefined: op_ready = ~reset, there is no comparison logic, and a dependent consumer reads the stale register value. Software must insert a NOP.

## Structure
- Shared package `cu_pkg` holds:
  - the unit-code constants (ALU=0, MUL=1, SHF=2, NOP=3);
  - the enable bit positions;
  - the stage-record typedef (valid, unit, rx, ry, rn, wb).
- One sub-module, `cu_wport_arb`: combinational write-port arbiter producing cu_wadd, cu_w_cuEn, cu_w_bcEn and bc_wr_ack.

## Test plan
- ALU op: rx=1, ry=2, rn=3, wb=1, accepted at E0 -> cu_alu_en=1 with raddx=1/raddy=2 in C1, then cu_w_cuEn=3'b001 with wadd=3 in C2.
- Stream of MUL then SHF with independent registers -> op_ready held at 1, enables 010 then 100 on consecutive cycles, busy high throughout.
- ALU op with rn=5 followed by MUL op with rx=5 -> op_ready=0 for exactly one cycle. With the macro undefined, op_ready stays 1 and the MUL read happens in C2.
- bc_wr_req with bc_wr_add=7 held across a writeback cycle -> no ack while cu_w_cuEn is nonzero; in the next free cycle bc_wr_ack=1, cu_w_bcEn=1, wadd=7.
- NOP and wb=0 ops -> no unit enable for the NOP, and cu_w_cuEn=0 in the writeback cycle of both.
- reset asserted in C1 of an ALU op -> all outputs 0 asynchronously, no write after release, op_ready=1 in the first cycle after release.
